// File: rtl/decode_module.sv
// ID stage: field decode, 2R1W register file with write-back bypass, control
// generation, load-use stall detection and the registered ID/EX operand bank.
module decode_module #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr_in,
  input  logic              instr_valid,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] imm_ext,
  output logic [4:0]        rs_idx,
  output logic [4:0]        rt_idx,
  output logic [4:0]        dest_idx,
  output logic [5:0]        opcode,
  output logic [5:0]        funct,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              branch,
  output logic              alu_src,
  output logic              mem_to_reg,
  output logic              valid_out,
  output logic              illegal
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic alu_src;
    logic mem_to_reg;
    logic illegal;
  } ctl_t;

  logic [NREGS-1:0][DATA_W-1:0] regs;

  logic [5:0]        op_f, fn_f;
  logic [4:0]        rs_f, rt_f, rd_f, dst_f;
  logic [DATA_W-1:0] imm_f, rs_rd, rt_rd;
  ctl_t              ctl_d, ctl_q;
  logic              uses_rt, load, vld_q;

  assign op_f  = instr_in[31:26];
  assign rs_f  = instr_in[25:21];
  assign rt_f  = instr_in[20:16];
  assign rd_f  = instr_in[15:11];
  assign fn_f  = instr_in[5:0];
  assign imm_f = {{(DATA_W-16){instr_in[15]}}, instr_in[15:0]};

  always_comb begin
    ctl_d   = '0;
    dst_f   = rt_f;
    uses_rt = 1'b0;
    case (op_f)
      OP_R: begin
        ctl_d.reg_write = 1'b1;
        dst_f           = rd_f;
        uses_rt         = 1'b1;
      end
      OP_LW: begin
        ctl_d.reg_write  = 1'b1;
        ctl_d.mem_read   = 1'b1;
        ctl_d.alu_src    = 1'b1;
        ctl_d.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        ctl_d.mem_write = 1'b1;
        ctl_d.alu_src   = 1'b1;
        uses_rt         = 1'b1;
      end
      OP_BEQ: begin
        ctl_d.branch = 1'b1;
        uses_rt      = 1'b1;
      end
      OP_ADDI: begin
        ctl_d.reg_write = 1'b1;
        ctl_d.alu_src   = 1'b1;
      end
      default: ctl_d.illegal = 1'b1;
    endcase
  end

  // Register 0 is hard-wired; a matching write-back this cycle wins over the array.
  always_comb begin
    rs_rd = '0;
    rt_rd = '0;
    if (rs_f != '0) rs_rd = (wb_en && wb_addr == rs_f) ? wb_data : regs[rs_f];
    if (rt_f != '0) rt_rd = (wb_en && wb_addr == rt_f) ? wb_data : regs[rt_f];
  end

  // Load-use hazard against the load currently sitting in ID/EX.
  assign stall = instr_valid & ctl_q.mem_read & (dest_idx != '0) &
                 ((dest_idx == rs_f) | (uses_rt & (dest_idx == rt_f)));

  assign load = instr_valid & ~flush & ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else if (wb_en && wb_addr != '0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Data fields load every cycle; only controls are forced to a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_data  <= '0;
      rt_data  <= '0;
      imm_ext  <= '0;
      rs_idx   <= '0;
      rt_idx   <= '0;
      dest_idx <= '0;
      opcode   <= '0;
      funct    <= '0;
      ctl_q    <= '0;
      vld_q    <= 1'b0;
    end else begin
      rs_data  <= rs_rd;
      rt_data  <= rt_rd;
      imm_ext  <= imm_f;
      rs_idx   <= rs_f;
      rt_idx   <= rt_f;
      dest_idx <= dst_f;
      opcode   <= op_f;
      funct    <= fn_f;
      ctl_q    <= load ? ctl_d : '0;
      vld_q    <= load;
    end
  end

  assign reg_write  = ctl_q.reg_write;
  assign mem_read   = ctl_q.mem_read;
  assign mem_write  = ctl_q.mem_write;
  assign branch     = ctl_q.branch;
  assign alu_src    = ctl_q.alu_src;
  assign mem_to_reg = ctl_q.mem_to_reg;
  assign illegal    = ctl_q.illegal;
  assign valid_out  = vld_q;

endmodule

// File: tb/tb_decode_module.sv
// Scoreboard bench for decode_module: expected ID/EX contents are queued as
// each instruction is driven and compared one edge later.
module tb_decode_module;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr_in = '0;
  logic        instr_valid = 1'b0, flush = 1'b0, wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        stall;
  logic [31:0] rs_data, rt_data, imm_ext;
  logic [4:0]  rs_idx, rt_idx, dest_idx;
  logic [5:0]  opcode, funct;
  logic        reg_write, mem_read, mem_write, branch, alu_src, mem_to_reg, valid_out, illegal;

  decode_module #(.DATA_W(32), .NREGS(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .instr_valid(instr_valid), .flush(flush),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .stall(stall),
    .rs_data(rs_data), .rt_data(rt_data), .imm_ext(imm_ext),
    .rs_idx(rs_idx), .rt_idx(rt_idx), .dest_idx(dest_idx), .opcode(opcode), .funct(funct),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
    .alu_src(alu_src), .mem_to_reg(mem_to_reg), .valid_out(valid_out), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // ctl = {reg_write, mem_read, mem_write, branch, alu_src, mem_to_reg, valid_out, illegal}
  localparam logic [7:0] C_BUB  = 8'b0000_0000;
  localparam logic [7:0] C_R    = 8'b1000_0010;
  localparam logic [7:0] C_LW   = 8'b1100_1110;
  localparam logic [7:0] C_SW   = 8'b0010_1010;
  localparam logic [7:0] C_BEQ  = 8'b0001_0010;
  localparam logic [7:0] C_ADDI = 8'b1000_1010;
  localparam logic [7:0] C_ILL  = 8'b0000_0011;

  typedef struct packed {
    logic [7:0]  ctl;
    logic [4:0]  dest;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
  } out_t;

  typedef struct packed {
    out_t v;
    out_t m;
  } exp_t;

  out_t obs;
  assign obs = {reg_write, mem_read, mem_write, branch, alu_src, mem_to_reg, valid_out, illegal,
                dest_idx, opcode, funct, rs_data, rt_data, imm_ext};

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // mb selects which data fields matter: {op/fn, imm, rt, rs, dest}; controls always matter.
  function automatic exp_t mk(input logic [7:0] c, input logic [4:0] d, input logic [5:0] o,
                              input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] i, input logic [4:0] mb);
    exp_t e;
    e.v     = {c, d, o, f, a, b, i};
    e.m.ctl = '1;
    e.m.dest = {5{mb[0]}};
    e.m.rs  = {32{mb[1]}};
    e.m.rt  = {32{mb[2]}};
    e.m.imm = {32{mb[3]}};
    e.m.op  = {6{mb[4]}};
    e.m.fn  = {6{mb[4]}};
    return e;
  endfunction

  task automatic drv(input logic [31:0] ins, input logic v, input logic f,
                     input logic we, input logic [4:0] wa, input logic [31:0] wd);
    instr_in = ins; instr_valid = v; flush = f; wb_en = we; wb_addr = wa; wb_data = wd;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    exp_t e;
    #2;
    sb.push_back(mk(C_BUB, 0, 0, 0, 0, 0, 0, 5'h1F));
    e = sb.pop_front(); n_chk++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL reset_outputs: got %h want %h", obs & e.m, e.v & e.m); end
    n_chk++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
    rst_n = 1'b1;
  endtask

  task automatic test_addi;
    exp_t e;
    drv(32'h0, 0, 0, 1, 5'd8, 32'hAA);
    sb.push_back(mk(C_BUB, 0, 0, 0, 0, 0, 0, 5'h00));
    tick;
    e = sb.pop_front(); n_chk++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL wb_bubble: got %h want %h", obs & e.m, e.v & e.m); end
    drv(32'h2109FFFF, 1, 0, 0, 0, 0);
    sb.push_back(mk(C_ADDI, 5'd9, 6'h08, 6'h3F, 32'hAA, 32'h0, 32'hFFFF_FFFF, 5'h1F));
    tick;
    e = sb.pop_front(); n_chk++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL addi: got %h want %h", obs & e.m, e.v & e.m); end
  endtask

  task automatic test_load_use;
    exp_t e;
    logic [31:0] lw_i[4] = '{32'h8C220004, 32'h8C220004, 32'h8C220004, 32'h8C200004};
    logic [4:0]  lw_d[4] = '{5'd2, 5'd2, 5'd2, 5'd0};
    logic [31:0] fo_i[4] = '{32'h00441820, 32'h00821820, 32'h20E20001, 32'h00000825};
    logic [7:0]  fo_c[4] = '{C_R, C_R, C_ADDI, C_R};
    logic [4:0]  fo_d[4] = '{5'd3, 5'd3, 5'd2, 5'd1};
    logic        st[4]   = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 4; k++) begin
      drv(lw_i[k], 1, 0, 0, 0, 0);
      sb.push_back(mk(C_LW, lw_d[k], 0, 0, 0, 0, 0, 5'h01));
      tick;
      e = sb.pop_front(); n_chk++;
      if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL lu_load[%0d]: got %h want %h", k, obs & e.m, e.v & e.m); end
      drv(fo_i[k], 1, 0, 0, 0, 0);
      #1; n_chk++;
      if (stall !== st[k]) begin n_fail++; $display("FAIL lu_stall[%0d]: got %b want %b", k, stall, st[k]); end
      if (st[k]) begin
        sb.push_back(mk(C_BUB, 0, 0, 0, 0, 0, 0, 5'h00));
        tick;
        e = sb.pop_front(); n_chk++;
        if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL lu_bubble[%0d]: got %h want %h", k, obs & e.m, e.v & e.m); end
        n_chk++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_release[%0d]: got %b want 0", k, stall); end
      end
      sb.push_back(mk(fo_c[k], fo_d[k], 0, 0, 0, 0, 0, 5'h01));
      tick;
      e = sb.pop_front(); n_chk++;
      if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL lu_follow[%0d]: got %h want %h", k, obs & e.m, e.v & e.m); end
    end
  endtask

  task automatic test_bypass;
    exp_t e;
    drv(32'h00A03022, 1, 0, 1, 5'd5, 32'h1234_5678);
    sb.push_back(mk(C_R, 5'd6, 6'h00, 6'h22, 32'h1234_5678, 32'h0, 32'h3022, 5'h1F));
    tick;
    e = sb.pop_front(); n_chk++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL bypass_rs: got %h want %h", obs & e.m, e.v & e.m); end
    drv(32'h00A03022, 1, 0, 0, 0, 0);
    sb.push_back(mk(C_R, 5'd6, 6'h00, 6'h22, 32'h1234_5678, 32'h0, 32'h3022, 5'h1F));
    tick;
    e = sb.pop_front(); n_chk++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL bypass_stored: got %h want %h", obs & e.m, e.v & e.m); end
    drv(32'h00095020, 1, 0, 1, 5'd9, 32'hCAFE_BABE);
    sb.push_back(mk(C_R, 5'd10, 6'h00, 6'h20, 32'h0, 32'hCAFE_BABE, 32'h5020, 5'h1F));
    tick;
    e = sb.pop_front(); n_chk++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL bypass_rt: got %h want %h", obs & e.m, e.v & e.m); end
  endtask

  task automatic test_r0;
    exp_t e;
    drv(32'h0, 0, 0, 1, 5'd0, 32'hFFFF_FFFF);
    sb.push_back(mk(C_BUB, 0, 0, 0, 0, 0, 0, 5'h00));
    tick;
    e = sb.pop_front(); n_chk++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL r0_write: got %h want %h", obs & e.m, e.v & e.m); end
    drv(32'h00000825, 1, 0, 1, 5'd0, 32'hFFFF_FFFF);
    sb.push_back(mk(C_R, 5'd1, 6'h00, 6'h25, 32'h0, 32'h0, 32'h0825, 5'h1F));
    tick;
    e = sb.pop_front(); n_chk++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL r0_read: got %h want %h", obs & e.m, e.v & e.m); end
  endtask

  task automatic test_controls;
    exp_t e;
    logic [31:0] ins[4]  = '{32'hAC220008, 32'h1022FFFE, 32'h21098000, 32'h21097FFF};
    logic [7:0]  c[4]    = '{C_SW, C_BEQ, C_ADDI, C_ADDI};
    logic [4:0]  d[4]    = '{5'd0, 5'd0, 5'd9, 5'd9};
    logic [5:0]  o[4]    = '{6'h2B, 6'h04, 6'h08, 6'h08};
    logic [5:0]  f[4]    = '{6'h08, 6'h3E, 6'h00, 6'h3F};
    logic [31:0] a[4]    = '{32'h0, 32'h0, 32'hAA, 32'hAA};
    logic [31:0] imm[4]  = '{32'h8, 32'hFFFF_FFFE, 32'hFFFF_8000, 32'h0000_7FFF};
    logic [4:0]  mb[4]   = '{5'h1A, 5'h18, 5'h1B, 5'h1B};
    for (int k = 0; k < 4; k++) begin
      drv(ins[k], 1, 0, 0, 0, 0);
      sb.push_back(mk(c[k], d[k], o[k], f[k], a[k], 32'h0, imm[k], mb[k]));
      tick;
      e = sb.pop_front(); n_chk++;
      if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL ctl[%0d]: got %h want %h", k, obs & e.m, e.v & e.m); end
    end
  endtask

  task automatic test_illegal_flush;
    exp_t e;
    logic [31:0] ins[5] = '{32'hFC000000, 32'hFC000000, 32'h8C220004, 32'h00441820, 32'hFC000000};
    logic        v[5]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        f[5]   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0]  c[5]   = '{C_ILL, C_BUB, C_LW, C_BUB, C_BUB};
    for (int k = 0; k < 5; k++) begin
      drv(ins[k], v[k], f[k], 0, 0, 0);
      sb.push_back(mk(c[k], 0, 0, 0, 0, 0, 0, 5'h00));
      tick;
      e = sb.pop_front(); n_chk++;
      if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL ill_flush[%0d]: got %h want %h", k, obs & e.m, e.v & e.m); end
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    drv(32'h8C220004, 1, 0, 0, 0, 0);
    sb.push_back(mk(C_LW, 5'd2, 0, 0, 0, 0, 0, 5'h01));
    tick;
    e = sb.pop_front(); n_chk++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL b2b_load: got %h want %h", obs & e.m, e.v & e.m); end
    drv(32'h00441820, 1, 0, 1, 5'd4, 32'h55);
    sb.push_back(mk(C_BUB, 0, 0, 0, 0, 0, 0, 5'h00));
    tick;
    e = sb.pop_front(); n_chk++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL b2b_bubble: got %h want %h", obs & e.m, e.v & e.m); end
    drv(32'h00441820, 1, 0, 0, 0, 0);
    sb.push_back(mk(C_R, 5'd3, 6'h00, 6'h20, 32'h0, 32'h55, 32'h1820, 5'h1F));
    tick;
    e = sb.pop_front(); n_chk++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL b2b_add: got %h want %h", obs & e.m, e.v & e.m); end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    drv(32'h8C220004, 1, 0, 1, 5'd5, 32'hDEAD_BEEF);
    #2;
    rst_n = 1'b0;
    #1;
    sb.push_back(mk(C_BUB, 0, 0, 0, 0, 0, 0, 5'h1F));
    e = sb.pop_front(); n_chk++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL rst_async: got %h want %h", obs & e.m, e.v & e.m); end
    n_chk++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", stall); end
    sb.push_back(mk(C_BUB, 0, 0, 0, 0, 0, 0, 5'h1F));
    tick;
    e = sb.pop_front(); n_chk++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL rst_hold: got %h want %h", obs & e.m, e.v & e.m); end
    rst_n = 1'b1;
    drv(32'h00A83820, 1, 0, 0, 0, 0);
    sb.push_back(mk(C_R, 5'd7, 6'h00, 6'h20, 32'h0, 32'h0, 32'h3820, 5'h1F));
    tick;
    e = sb.pop_front(); n_chk++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL rst_regfile: got %h want %h", obs & e.m, e.v & e.m); end
  endtask

  initial begin
    test_reset;
    test_addi;
    test_load_use;
    test_bypass;
    test_r0;
    test_controls;
    test_illegal_flush;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
